// File: rtl/osecpu_pkg.sv
// Shared opcode values, instruction field positions and FSM state encoding for the OSECPU execution unit.
package osecpu_pkg;

    localparam logic [7:0] OP_LIMM16 = 8'h02;
    localparam logic [7:0] OP_CP     = 8'hd2;
    localparam logic [7:0] OP_ADD    = 8'h14;
    localparam logic [7:0] OP_SUB    = 8'h15;
    localparam logic [7:0] OP_CPDR   = 8'hd3;

    localparam int OP_LSB  = 24;
    localparam int R0_LSB  = 18;
    localparam int R1_LSB  = 12;
    localparam int R2_LSB  = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

endpackage

// File: rtl/osecpu_exec_unit_decode.sv
// Pure opcode classifier: which operands an instruction reads and where its result goes.
module osecpu_decode
    import osecpu_pkg::*;
(
    input  logic [7:0] op,
    output logic       uses_r1,
    output logic       uses_r2,
    output logic       uses_alu,
    output logic       writes_reg,
    output logic       is_dr,
    output logic       is_illegal
);

    always_comb begin
        uses_r1    = 1'b0;
        uses_r2    = 1'b0;
        uses_alu   = 1'b0;
        writes_reg = 1'b0;
        is_dr      = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_LIMM16: writes_reg = 1'b1;
            OP_CP: begin
                uses_r1    = 1'b1;
                writes_reg = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                uses_r1    = 1'b1;
                uses_r2    = 1'b1;
                uses_alu   = 1'b1;
                writes_reg = 1'b1;
            end
            OP_CPDR: begin
                uses_r1 = 1'b1;
                is_dr   = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/osecpu_exec_unit.sv
// Multi-cycle OSECPU executor: IDLE -> READ -> EXEC -> WB, one instruction in flight.
// Ready only in IDLE; LIMM16 and illegal opcodes skip straight to WB.
module osecpu_exec_unit
    import osecpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 6,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [RADDR_W-1:0] ireg_r0,
    output logic [RADDR_W-1:0] ireg_r1,
    input  logic [DATA_W-1:0]  ireg_d0,
    input  logic [DATA_W-1:0]  ireg_d1,
    output logic [7:0]         alu_op,
    output logic [DATA_W-1:0]  alu_d0,
    output logic [DATA_W-1:0]  alu_d1,
    input  logic [DATA_W-1:0]  alu_dout,
    output logic               ireg_we,
    output logic [RADDR_W-1:0] ireg_rw,
    output logic [DATA_W-1:0]  ireg_dw,
    output logic               dr_valid,
    output logic [DATA_W-1:0]  dr_data,
    output logic               illegal
);

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic [DATA_W-1:0]    dr_data_q, dr_data_d;
    logic [7:0]           op_sel;
    logic                 uses_r1, uses_r2, uses_alu, writes_reg, is_dr, is_illegal;

    // In IDLE the incoming word is classified so the accept cycle can pick the next state.
    assign op_sel = (state_q == ST_IDLE) ? instr[OP_LSB +: 8] : instr_q[OP_LSB +: 8];

    osecpu_decode u_decode (
        .op         (op_sel),
        .uses_r1    (uses_r1),
        .uses_r2    (uses_r2),
        .uses_alu   (uses_alu),
        .writes_reg (writes_reg),
        .is_dr      (is_dr),
        .is_illegal (is_illegal)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        wb_data_d   = wb_data_q;
        dr_data_d   = dr_data_q;
        instr_ready = 1'b0;
        ireg_r0     = '0;
        ireg_r1     = '0;
        alu_op      = '0;
        alu_d0      = '0;
        alu_d1      = '0;
        ireg_we     = 1'b0;
        ireg_rw     = '0;
        ireg_dw     = '0;
        dr_valid    = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = !reset;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = uses_r1 ? ST_READ : ST_WB;
                end
            end
            ST_READ: begin
                ireg_r0 = uses_r1 ? instr_q[R1_LSB +: RADDR_W] : '0;
                ireg_r1 = uses_r2 ? instr_q[R2_LSB +: RADDR_W] : '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (uses_alu) begin
                    alu_op    = instr_q[OP_LSB +: 8];
                    alu_d0    = ireg_d0;
                    alu_d1    = ireg_d1;
                    wb_data_d = alu_dout;
                end else if (is_dr) begin
                    dr_data_d = ireg_d0;
                end else begin
                    wb_data_d = ireg_d0;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                ireg_we = writes_reg;
                if (writes_reg) begin
                    ireg_rw = instr_q[R0_LSB +: RADDR_W];
                    // Immediate loads never pass through EXEC, so their value comes from the word itself.
                    ireg_dw = uses_r1 ? wb_data_q : DATA_W'($signed(instr_q[IMM_LSB +: 16]));
                end
                dr_valid = is_dr;
                illegal  = is_illegal;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dr_data = dr_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            wb_data_q <= '0;
            dr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            wb_data_q <= wb_data_d;
            dr_data_q <= dr_data_d;
        end
    end

endmodule

// File: tb/tb_osecpu_exec_unit.sv
// Bench for osecpu_exec_unit: register-file/ALU environment plus an instruction-level reference model.
module tb_osecpu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [5:0]  ireg_r0, ireg_r1, ireg_rw;
    logic [31:0] ireg_d0, ireg_d1, alu_d0, alu_d1, alu_dout, ireg_dw, dr_data;
    logic [7:0]  alu_op;
    logic        ireg_we, dr_valid, illegal;

    always #5 clk = ~clk;

    osecpu_exec_unit #(.DATA_W(32), .RADDR_W(6), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ireg_r0(ireg_r0), .ireg_r1(ireg_r1), .ireg_d0(ireg_d0),
        .ireg_d1(ireg_d1), .alu_op(alu_op), .alu_d0(alu_d0), .alu_d1(alu_d1),
        .alu_dout(alu_dout), .ireg_we(ireg_we), .ireg_rw(ireg_rw), .ireg_dw(ireg_dw),
        .dr_valid(dr_valid), .dr_data(dr_data), .illegal(illegal)
    );

    // Environment: register file with one-cycle read latency and a combinational ALU.
    logic [31:0] rf_mem [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_a = '0;
    logic [31:0] poke_d = '0;
    always @(posedge clk) begin
        if (poke_en) rf_mem[poke_a] <= poke_d;
        else if (ireg_we) rf_mem[ireg_rw] <= ireg_dw;
        ireg_d0 <= rf_mem[ireg_r0];
        ireg_d1 <= rf_mem[ireg_r1];
    end
    assign alu_dout = (alu_op == 8'h14) ? alu_d0 + alu_d1 :
                      (alu_op == 8'h15) ? alu_d0 - alu_d1 : 32'h0;

    logic [31:0] ref_regs [64];
    logic [31:0] ref_dr = '0;
    int passed = 0;
    int total  = 0;

    logic [31:0] o_we [1:4], o_rw [1:4], o_dw [1:4], o_dv [1:4], o_dd [1:4];
    logic [31:0] o_ill [1:4], o_rdy [1:4], o_r0 [1:4], o_r1 [1:4], o_op [1:4];

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c);
        return {op, a, b, c, 6'b0};
    endfunction

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_a = a; poke_d = d; ref_regs[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Present one word, wait (bounded) for acceptance, record cycles T+1..T+4.
    task automatic issue(input logic [31:0] w);
        int n;
        @(negedge clk);
        instr = w; instr_valid = 1'b1; n = 0;
        while (!instr_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (instr_ready !== 1'b1) $display("FAIL issue_timeout ready=%0b required 1", instr_ready);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) instr_valid = 1'b0;
            o_we[k] = 32'(ireg_we); o_rw[k] = 32'(ireg_rw); o_dw[k] = ireg_dw;
            o_dv[k] = 32'(dr_valid); o_dd[k] = dr_data; o_ill[k] = 32'(illegal);
            o_rdy[k] = 32'(instr_ready); o_r0[k] = 32'(ireg_r0); o_r1[k] = 32'(ireg_r1);
            o_op[k] = 32'(alu_op);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({instr_ready, ireg_we, dr_valid, illegal} !== 4'b0) $display("FAIL reset_strobes got %b required 0000", {instr_ready, ireg_we, dr_valid, illegal}); else passed++;
        total++; if ({dr_data, ireg_dw, alu_d0, alu_d1} !== 128'h0) $display("FAIL reset_data got %h required 0", {dr_data, ireg_dw, alu_d0, alu_d1}); else passed++;
        total++; if ({ireg_r0, ireg_r1, ireg_rw, alu_op} !== 26'h0) $display("FAIL reset_addr got %h required 0", {ireg_r0, ireg_r1, ireg_rw, alu_op}); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (instr_ready !== 1'b1) $display("FAIL reset_release_ready got %0b required 1", instr_ready); else passed++;
        for (int i = 0; i < 64; i++) poke(6'(i), 32'h0);
    endtask

    task automatic test_limm();
        issue({8'h02, 6'd5, 2'b00, 16'h8001});
        total++; if (o_we[1] !== 1 || o_rw[1] !== 5 || o_dw[1] !== 32'hFFFF8001) $display("FAIL limm_wb we=%0h rw=%0h dw=%h required 1/5/ffff8001", o_we[1], o_rw[1], o_dw[1]); else passed++;
        total++; if (o_rdy[1] !== 0 || o_rdy[2] !== 1) $display("FAIL limm_ready t1=%0h t2=%0h required 0/1", o_rdy[1], o_rdy[2]); else passed++;
        total++; if (o_we[2] !== 0) $display("FAIL limm_single_we got %0h required 0", o_we[2]); else passed++;
    endtask

    task automatic test_add();
        poke(3, 32'd7); poke(4, 32'd5);
        issue(enc(8'h14, 2, 3, 4));
        total++; if (o_r0[1] !== 3 || o_r1[1] !== 4) $display("FAIL add_read r0=%0h r1=%0h required 3/4", o_r0[1], o_r1[1]); else passed++;
        total++; if (o_op[2] !== 32'h14 || o_op[1] !== 0) $display("FAIL add_aluop t2=%0h t1=%0h required 14/0", o_op[2], o_op[1]); else passed++;
        total++; if (o_we[3] !== 1 || o_rw[3] !== 2 || o_dw[3] !== 12) $display("FAIL add_wb we=%0h rw=%0h dw=%0h required 1/2/12", o_we[3], o_rw[3], o_dw[3]); else passed++;
        total++; if (o_we[2] !== 0 || o_rdy[3] !== 0 || o_rdy[4] !== 1) $display("FAIL add_timing we2=%0h rdy3=%0h rdy4=%0h required 0/0/1", o_we[2], o_rdy[3], o_rdy[4]); else passed++;
    endtask

    task automatic test_sub_cp();
        poke(10, 32'd0); poke(11, 32'd1); poke(9, 32'hABCD);
        issue(enc(8'h15, 12, 10, 11));
        total++; if (o_we[3] !== 1 || o_rw[3] !== 12 || o_dw[3] !== 32'hFFFFFFFF) $display("FAIL sub_wrap we=%0h rw=%0h dw=%h required 1/c/ffffffff", o_we[3], o_rw[3], o_dw[3]); else passed++;
        issue(enc(8'hd2, 1, 9, 0));
        total++; if (o_r0[1] !== 9 || o_r1[1] !== 0 || o_op[2] !== 0) $display("FAIL cp_read r0=%0h r1=%0h op=%0h required 9/0/0", o_r0[1], o_r1[1], o_op[2]); else passed++;
        total++; if (o_we[3] !== 1 || o_rw[3] !== 1 || o_dw[3] !== 32'hABCD) $display("FAIL cp_wb we=%0h rw=%0h dw=%h required 1/1/abcd", o_we[3], o_rw[3], o_dw[3]); else passed++;
    endtask

    task automatic test_cpdr();
        poke(7, 32'h1234);
        issue(enc(8'hd3, 0, 7, 0));
        total++; if (o_dv[3] !== 1 || o_dd[3] !== 32'h1234) $display("FAIL cpdr_out dv=%0h dd=%h required 1/1234", o_dv[3], o_dd[3]); else passed++;
        total++; if ((o_we[1] | o_we[2] | o_we[3] | o_we[4]) !== 0) $display("FAIL cpdr_no_we got %0h required 0", o_we[1] | o_we[2] | o_we[3] | o_we[4]); else passed++;
        total++; if (o_dv[4] !== 0 || o_dd[4] !== 32'h1234 || o_rdy[4] !== 1) $display("FAIL cpdr_hold dv=%0h dd=%h rdy=%0h required 0/1234/1", o_dv[4], o_dd[4], o_rdy[4]); else passed++;
        ref_dr = 32'h1234;
    endtask

    task automatic test_illegal_back_to_back();
        @(negedge clk);
        instr = 32'hFF000000; instr_valid = 1'b1;
        @(negedge clk);
        total++; if (illegal !== 1 || ireg_we !== 0 || instr_ready !== 0) $display("FAIL ill_t1 ill=%0b we=%0b rdy=%0b required 1/0/0", illegal, ireg_we, instr_ready); else passed++;
        instr = {8'h02, 6'd6, 2'b00, 16'h0042};
        @(negedge clk);
        total++; if (instr_ready !== 1 || illegal !== 0) $display("FAIL ill_t2 rdy=%0b ill=%0b required 1/0", instr_ready, illegal); else passed++;
        @(negedge clk);
        instr_valid = 1'b0;
        total++; if (ireg_we !== 1 || ireg_rw !== 6 || ireg_dw !== 32'h42) $display("FAIL b2b_second we=%0b rw=%0h dw=%h required 1/6/42", ireg_we, ireg_rw, ireg_dw); else passed++;
        @(negedge clk);
        total++; if (instr_ready !== 1 || ireg_we !== 0) $display("FAIL b2b_done rdy=%0b we=%0b required 1/0", instr_ready, ireg_we); else passed++;
    endtask

    task automatic test_reset_mid_op();
        poke(2, 32'h55); poke(3, 32'd7); poke(4, 32'd5);
        @(negedge clk);
        instr = enc(8'h14, 2, 3, 4); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        total++; if (alu_op !== 8'h14) $display("FAIL rst_exec_reached op=%0h required 14", alu_op); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (ireg_we !== 0 || instr_ready !== 0 || alu_op !== 0 || dr_data !== 0) $display("FAIL rst_mid we=%0b rdy=%0b op=%0h dd=%h required 0/0/0/0", ireg_we, instr_ready, alu_op, dr_data); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (instr_ready !== 1 || ireg_we !== 0) $display("FAIL rst_release rdy=%0b we=%0b required 1/0", instr_ready, ireg_we); else passed++;
        issue(enc(8'hd3, 0, 2, 0));
        total++; if (o_dd[3] !== 32'h55) $display("FAIL rst_aborted_write r2=%h required 55", o_dd[3]); else passed++;
        ref_dr = 32'h55;
    endtask

    task automatic test_random(input int n);
        logic [7:0]  ops [5];
        logic [7:0]  op;
        logic [31:0] w, rnd, res, exp_r0, exp_r1, exp_op;
        logic [5:0]  a0, a1, a2;
        int wcyc, drcyc, back;
        logic ill;
        ops[0] = 8'h02; ops[1] = 8'hd2; ops[2] = 8'h14; ops[3] = 8'h15; ops[4] = 8'hd3;
        for (int i = 0; i < 64; i++) poke(6'(i), $urandom());
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 5) begin
                op = 8'($urandom());
                while (op == 8'h02 || op == 8'hd2 || op == 8'h14 || op == 8'h15 || op == 8'hd3) op = 8'($urandom());
            end else op = ops[$urandom_range(0, 4)];
            rnd = $urandom();
            w = {op, rnd[23:0]};
            a0 = w[23:18]; a1 = w[17:12]; a2 = w[11:6];
            wcyc = 0; drcyc = 0; back = 4; ill = 1'b0; res = '0;
            exp_r0 = 0; exp_r1 = 0; exp_op = 0;
            case (op)
                8'h02: begin res = {{16{w[15]}}, w[15:0]}; wcyc = 1; back = 2; end
                8'hd2: begin res = ref_regs[a1]; wcyc = 3; exp_r0 = 32'(a1); end
                8'h14: begin res = ref_regs[a1] + ref_regs[a2]; wcyc = 3; exp_r0 = 32'(a1); exp_r1 = 32'(a2); exp_op = 32'h14; end
                8'h15: begin res = ref_regs[a1] - ref_regs[a2]; wcyc = 3; exp_r0 = 32'(a1); exp_r1 = 32'(a2); exp_op = 32'h15; end
                8'hd3: begin ref_dr = ref_regs[a1]; drcyc = 3; exp_r0 = 32'(a1); end
                default: begin ill = 1'b1; back = 2; end
            endcase
            issue(w);
            if (wcyc != 0) ref_regs[a0] = res;
            total++; if (o_r0[1] !== exp_r0 || o_r1[1] !== exp_r1) $display("FAIL rand%0d_read op=%h r0=%0h r1=%0h required %0h/%0h", i, op, o_r0[1], o_r1[1], exp_r0, exp_r1); else passed++;
            total++; if (o_op[2] !== exp_op) $display("FAIL rand%0d_aluop op=%h got %0h required %0h", i, op, o_op[2], exp_op); else passed++;
            for (int k = 1; k <= 4; k++) begin
                total++; if (o_we[k] !== 32'(k == wcyc)) $display("FAIL rand%0d_we op=%h k=%0d got %0h required %0d", i, op, k, o_we[k], k == wcyc); else passed++;
                total++; if (o_dv[k] !== 32'(k == drcyc)) $display("FAIL rand%0d_dv op=%h k=%0d got %0h required %0d", i, op, k, o_dv[k], k == drcyc); else passed++;
                total++; if (o_ill[k] !== 32'(ill && k == 1)) $display("FAIL rand%0d_ill op=%h k=%0d got %0h required %0d", i, op, k, o_ill[k], ill && k == 1); else passed++;
                total++; if (o_rdy[k] !== 32'(k >= back)) $display("FAIL rand%0d_rdy op=%h k=%0d got %0h required %0d", i, op, k, o_rdy[k], k >= back); else passed++;
            end
            if (wcyc != 0) begin
                total++; if (o_rw[wcyc] !== 32'(a0) || o_dw[wcyc] !== res) $display("FAIL rand%0d_wb op=%h rw=%0h dw=%h required %0h/%h", i, op, o_rw[wcyc], o_dw[wcyc], a0, res); else passed++;
            end
            total++; if (o_dd[4] !== ref_dr) $display("FAIL rand%0d_dr op=%h got %h required %h", i, op, o_dd[4], ref_dr); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_limm();
        test_add();
        test_sub_cp();
        test_cpdr();
        test_illegal_back_to_back();
        test_reset_mid_op();
        test_random(60);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
